// File: rtl/lamp_pkg.sv
// Shared types and helpers for the lamp sequencer: mode decoding and width math.
package lamp_pkg;

  typedef enum logic [1:0] {
    M_CLEAR    = 2'd0,
    M_MANUAL   = 2'd1,
    M_AUTO     = 2'd2,
    M_RESERVED = 2'd3
  } mode_e;

  localparam int unsigned MODE_CLEAR = 0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((longint'(1) << r) < longint'(v)) r++;
    return r;
  endfunction

  // All-ones switch pattern for a given switch width.
  function automatic int unsigned mode_auto(input int unsigned sw_w);
    return (1 << sw_w) - 1;
  endfunction

  function automatic mode_e decode_mode(input int unsigned sw_val,
                                        input int unsigned sw_w,
                                        input int unsigned num_ch);
    if (sw_val == MODE_CLEAR)          return M_CLEAR;
    else if (sw_val == mode_auto(sw_w)) return M_AUTO;
    else if (sw_val <= num_ch)          return M_MANUAL;
    else                                return M_RESERVED;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stable-count debouncer and rising-edge pulse.
module btn_debounce
  import lamp_pkg::*;
#(
  parameter int unsigned DB_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (clog2(DB_CYC) < 1) ? 1 : clog2(DB_CYC);

  logic          sync1;
  logic          btn_s;
  logic          level;
  logic          level_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      btn_s      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= btn;
      btn_s      <= sync1;
      level_prev <= level;
      if (btn_s == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYC - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_prev;

endmodule

// File: rtl/lamp_sequencer.sv
// N-channel lamp controller: clear / manual per-channel / automatic cycling selected by switches.
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned SW_W      = 3,
  parameter int unsigned BTN_W     = 4,
  parameter int unsigned DB_CYC    = 50000,
  parameter int unsigned DWELL_CYC = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw,
  input  logic [BTN_W-1:0]  btn,
  output logic [NUM_CH-1:0] ch_out,
  output logic              auto_active,
  output logic [BTN_W-1:0]  press_evt
);

  localparam int unsigned DW = (clog2(DWELL_CYC) < 1) ? 1 : clog2(DWELL_CYC);
  localparam int unsigned IW = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);

  logic [SW_W-1:0]   sw_m;
  logic [SW_W-1:0]   sw_s;
  logic [BTN_W-1:0]  press_raw;
  mode_e             mode;
  mode_e             prev_mode;
  logic [DW-1:0]     dwell_cnt;
  logic [DW-1:0]     dwell_n;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_n;
  logic              paused;
  logic              paused_n;
  logic [NUM_CH-1:0] ch_n;
  logic              auto_n;

  for (genvar g = 0; g < BTN_W; g++) begin : g_btn
    btn_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[g]),
      .press (press_raw[g])
    );
  end

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_CH - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    mode = decode_mode(32'(sw_s), SW_W, NUM_CH);
  end

  always_comb begin
    ch_n     = ch_out;
    idx_n    = idx;
    dwell_n  = dwell_cnt;
    paused_n = paused;
    auto_n   = 1'b0;
    case (mode)
      M_CLEAR: ch_n = '0;
      M_MANUAL: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (i == 32'(sw_s) - 1) begin
            if (press_evt[2])      ch_n[i] = 1'b0;
            else if (press_evt[1]) ch_n[i] = 1'b1;
          end
        end
      end
      M_AUTO: begin
        if (prev_mode != M_AUTO) begin
          idx_n    = '0;
          dwell_n  = '0;
          paused_n = 1'b0;
        end else begin
          paused_n = paused ^ press_evt[1];
          // A step overrides the dwell path, so a coinciding terminal count advances once.
          if (press_evt[3]) begin
            idx_n   = next_idx(idx);
            dwell_n = '0;
          end else if (!paused) begin
            if (dwell_cnt == DW'(DWELL_CYC - 1)) begin
              idx_n   = next_idx(idx);
              dwell_n = '0;
            end else begin
              dwell_n = dwell_cnt + 1'b1;
            end
          end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          ch_n[i] = (32'(idx_n) == i);
        end
        auto_n = ~paused_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_m        <= '0;
      sw_s        <= '0;
      press_evt   <= '0;
      prev_mode   <= M_CLEAR;
      ch_out      <= '0;
      auto_active <= 1'b0;
      idx         <= '0;
      dwell_cnt   <= '0;
      paused      <= 1'b0;
    end else begin
      sw_m        <= sw;
      sw_s        <= sw_m;
      press_evt   <= press_raw;
      prev_mode   <= mode;
      ch_out      <= ch_n;
      auto_active <= auto_n;
      idx         <= idx_n;
      dwell_cnt   <= dwell_n;
      paused      <= paused_n;
    end
  end

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer with short debounce/dwell constants.
module tb_lamp_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] sw;
  logic [3:0] btn;
  logic [2:0] ch_out;
  logic       auto_active;
  logic [3:0] press_evt;

  int n_chk;
  int n_err;

  lamp_sequencer #(
    .NUM_CH    (3),
    .SW_W      (3),
    .BTN_W     (4),
    .DB_CYC    (4),
    .DWELL_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .btn         (btn),
    .ch_out      (ch_out),
    .auto_active (auto_active),
    .press_evt   (press_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold buttons for 8 edges: event shows on edge 7, lamps react on edge 8; then release.
  task automatic press_chk(input logic [3:0] b);
    btn = b;
    repeat (7) tick();
    chk("press_evt_pulse", 32'(press_evt), 32'(b));
    tick();
    chk("press_evt_single", 32'(press_evt), 0);
    btn = '0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    sw  = 3'd7;
    btn = 4'hF;

    // Reset
    tick();
    chk("rst_ch_out", 32'(ch_out), 0);
    chk("rst_auto", 32'(auto_active), 0);
    chk("rst_press", 32'(press_evt), 0);
    tick();
    chk("rst2_ch_out", 32'(ch_out), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ch_out", 32'(ch_out), 0);
    chk("post_rst_auto", 32'(auto_active), 0);
    chk("post_rst_press", 32'(press_evt), 0);
    sw  = 3'd0;
    btn = '0;
    repeat (6) tick();
    chk("settle_clear", 32'(ch_out), 0);
    chk("settle_auto", 32'(auto_active), 0);

    // Debounce: short glitch ignored, held press lands at t+7
    sw = 3'd2;
    repeat (4) tick();
    btn = 4'b0010;
    repeat (3) tick();
    btn = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_press", 32'(press_evt), 0);
      chk("glitch_ch_out", 32'(ch_out), 0);
    end
    btn = 4'b0010;
    repeat (6) tick();
    chk("db_early", 32'(press_evt), 0);
    tick();
    chk("db_evt_t6", 32'(press_evt), 'b0010);
    chk("db_ch_before", 32'(ch_out), 0);
    tick();
    chk("db_evt_gone", 32'(press_evt), 0);
    chk("db_ch_t7", 32'(ch_out), 'b010);
    btn = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("release_no_evt", 32'(press_evt), 0);
    end

    // Manual set/clear
    sw = 3'd0;
    repeat (4) tick();
    chk("clear_mode", 32'(ch_out), 0);
    sw = 3'd1;
    repeat (4) tick();
    press_chk(4'b0110);
    chk("set_clr_clear_wins", 32'(ch_out), 'b000);
    repeat (8) tick();
    press_chk(4'b0010);
    chk("manual_set_ch0", 32'(ch_out), 'b001);
    repeat (8) tick();
    sw = 3'd3;
    repeat (4) tick();
    press_chk(4'b0010);
    chk("manual_set_ch2", 32'(ch_out), 'b101);
    repeat (8) tick();
    press_chk(4'b0100);
    chk("manual_clr_ch2", 32'(ch_out), 'b001);
    repeat (8) tick();
    press_chk(4'b0010);
    chk("manual_reset_ch2", 32'(ch_out), 'b101);
    repeat (8) tick();
    sw = 3'd0;
    repeat (2) tick();
    chk("clear_sync_lag", 32'(ch_out), 'b101);
    tick();
    chk("clear_after_sync", 32'(ch_out), 0);

    // AUTO cycling: entry edge E shows 001
    sw = 3'd7;
    repeat (3) tick();
    chk("auto_entry_ch", 32'(ch_out), 'b001);
    chk("auto_entry_active", 32'(auto_active), 1);
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk("auto_cycle_ch", 32'(ch_out), 32'(1) << ((i / 8) % 3));
      chk("auto_cycle_active", 32'(auto_active), 1);
    end

    // Pause lands at E+38 while showing 010
    repeat (6) tick();
    press_chk(4'b0010);
    chk("pause_ch", 32'(ch_out), 'b010);
    chk("pause_active", 32'(auto_active), 0);
    for (int i = 0; i < 22; i++) begin
      tick();
      chk("paused_frozen", 32'(ch_out), 'b010);
      chk("paused_inactive", 32'(auto_active), 0);
    end
    press_chk(4'b1000);
    chk("step_while_paused", 32'(ch_out), 'b100);
    chk("step_still_paused", 32'(auto_active), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("step_frozen", 32'(ch_out), 'b100);
    end
    press_chk(4'b0010);
    chk("resume_ch", 32'(ch_out), 'b100);
    chk("resume_active", 32'(auto_active), 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("resume_dwell", 32'(ch_out), (i < 8) ? 'b100 : 'b001);
    end

    // Mode transitions
    repeat (16) tick();
    chk("auto_at_100", 32'(ch_out), 'b100);
    sw = 3'd2;
    repeat (4) tick();
    chk("leave_auto_hold", 32'(ch_out), 'b100);
    chk("leave_auto_inactive", 32'(auto_active), 0);
    press_chk(4'b0010);
    chk("manual_after_auto", 32'(ch_out), 'b110);
    repeat (8) tick();
    sw = 3'd7;
    repeat (3) tick();
    chk("reenter_auto_ch", 32'(ch_out), 'b001);
    chk("reenter_auto_active", 32'(auto_active), 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("reenter_dwell", 32'(ch_out), (i < 8) ? 'b001 : 'b010);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
